sync_mem_ctrl: RTL and testbench
================================

// Module: sync_mem_ctrl
// PURPOSE
//  Parametrised single-port synchronous RAM with valid/ready request port, byte enables,
//  configurable read latency and a hardware clear sweep after reset or on demand.
//  Successor to the plain CPU data/instruction memory; sits between CPU load/store unit and storage.
// PARAMETERS
//  ADDR_W    8  address width; depth = 2**ADDR_W words
//  DATA_W    16 word width; must be a multiple of 8
//  RD_LAT    1  read latency in cycles, legal 1..4 (elaboration $error otherwise)
//  CLR_RST   1  1: run clear sweep after reset; 0: ready immediately, contents undefined
// PORTS
//  clk          in   1         clock, all logic on posedge
//  rst_n        in   1         asynchronous active-low reset
//  req_valid    in   1         request present
//  req_ready    out  1         controller accepts request this cycle
//  req_write    in   1         1 = write, 0 = read
//  req_addr     in   ADDR_W    word address
//  req_wdata    in   DATA_W    write data
//  req_be       in   DATA_W/8  byte enables; bit i covers bits [8i+7:8i]
//  clr_start    in   1         pulse: start clear sweep
//  perr_inject  in   1         invert stored parity bit 0 of this write (parity build only)
//  rsp_valid    out  1         read data valid (1-cycle pulse per read)
//  rsp_rdata    out  DATA_W    read data
//  rsp_perr     out  1         parity error on this response, qualified by rsp_valid
//  busy         out  1         clear sweep in progress
// BEHAVIOUR
//  Reset (async assert, sync deassert by upstream): rsp_valid=0, rsp_rdata=0, rsp_perr=0, pipeline
//   flushed; state=CLEAR, busy=1, req_ready=0 if CLR_RST=1, else state=RUN, busy=0, req_ready=1.
//  FSM: CLEAR -> RUN when sweep counter writes address 2**ADDR_W-1; RUN -> DRAIN on clr_start;
//   DRAIN -> CLEAR when read pipeline empty. clr_start outside RUN is ignored.
//  CLEAR: writes 0 (and correct parity) to one address per cycle from 0 upward; 2**ADDR_W cycles.
//  req_ready = (state==RUN). Handshake fires on req_valid & req_ready; no ready-on-valid dependency.
//  Write: bytes with req_be[i]=1 updated at the accept edge; others keep old value; no response.
//  Write with req_be=0: no storage change, legal.
//  Read: array read at accept edge, then RD_LAT-1 pipeline stages; rsp_valid rises exactly RD_LAT
//   cycles after accept edge. Back-to-back reads give back-to-back responses, in order.
//  Read of address written on previous accept returns new data (no hazard). One access per cycle.
//  Response port has no backpressure; consumer must always sink.
//  rsp_rdata holds last value when rsp_valid=0 (cleared only by reset).
//  Reset mid-sweep: sweep restarts at address 0 after reset. Reset mid-read: response lost.
//  Assertions: no X on req_addr/req_write when handshake fires; rsp_valid never high in CLEAR.
// CONFIGURATION
//  MEM_PARITY_EN defined: one even-parity bit per byte stored alongside data; checked on read;
//   rsp_perr=1 with rsp_valid if any byte mismatches; perr_inject flips stored bit 0 on write.
//  MEM_PARITY_EN undefined: no parity storage; rsp_perr tied 0; perr_inject ignored.
// TESTING
//  1 reset, CLR_RST=1, ADDR_W=4 -> busy=1 for 16 cycles, req_ready=0; read all 16 -> all 0x0000.
//  2 write 0xBEEF @0x3 be=11, read 0x3 -> rsp_valid exactly RD_LAT cycles later (RD_LAT=1,3), 0xBEEF.
//  3 write 0xBEEF @0x3, then 0x1234 be=01 -> read returns 0xBE34; be=00 write leaves 0xBE34.
//  4 back-to-back reads 0x0..0x3 after distinct writes -> 4 consecutive rsp_valid, in-order data.
//  5 clr_start with 2 reads in flight -> both responses delivered, then busy=1, all words read 0.
//  6 MEM_PARITY_EN: write 0x00FF with perr_inject=1, read -> rsp_perr=1; normal write/read -> 0.

Source files
------------

// File: rtl/sync_mem_ctrl.sv
// Single-port synchronous RAM behind a valid/ready request port, with byte enables, an
// RD_LAT-deep read pipeline and a clear sweep. Define MEM_PARITY_EN for per-byte even parity.
module sync_mem_ctrl #(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned RD_LAT  = 1,
   parameter bit          CLR_RST = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_write,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_be,
   input  logic                clr_start,
   input  logic                perr_inject,
   output logic                rsp_valid,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_perr,
   output logic                busy
);
   localparam int unsigned NB    = DATA_W / 8;
   localparam int unsigned DEPTH = 2 ** ADDR_W;

   if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
      $error("sync_mem_ctrl: RD_LAT must be in 1..4");
   end
   if (DATA_W % 8 != 0) begin : g_bad_width
      $error("sync_mem_ctrl: DATA_W must be a multiple of 8");
   end

   typedef enum logic [1:0] {StClear, StRun, StDrain} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   clr_addr_q;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic                fire, rd_fire, wr_fire, clr_last, pipe_empty, rd_perr;
   logic [RD_LAT-1:0]   vld_q;
   logic [RD_LAT-1:0]   perr_q;
   logic [DATA_W-1:0]   dat_q [RD_LAT];

   assign fire       = req_valid & req_ready;
   assign rd_fire    = fire & ~req_write;
   assign wr_fire    = fire & req_write;
   assign clr_last   = (clr_addr_q == {ADDR_W{1'b1}});
   assign pipe_empty = ~|vld_q;

   // FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= CLR_RST ? StClear : StRun;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StClear: if (clr_last)   state_d = StRun;
         StRun:   if (clr_start)  state_d = StDrain;
         StDrain: if (pipe_empty) state_d = StClear;
         default:                 state_d = StRun;
      endcase
   end

   // FSM: outputs
   always_comb begin
      req_ready = (state_q == StRun);
      busy      = (state_q == StClear);
   end

   // Sweep counter wraps back to 0 on its last write, ready for the next sweep.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clr_addr_q <= '0;
      end else if (state_q == StClear) begin
         clr_addr_q <= clr_addr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (state_q == StClear) begin
         mem[clr_addr_q] <= '0;
      end else if (wr_fire) begin
         for (int i = 0; i < NB; i++) begin
            if (req_be[i]) mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
         end
      end
   end

`ifdef MEM_PARITY_EN
   logic [NB-1:0] par [DEPTH];

   always_ff @(posedge clk) begin
      if (state_q == StClear) begin
         par[clr_addr_q] <= '0;
      end else if (wr_fire) begin
         for (int i = 0; i < NB; i++) begin
            if (req_be[i]) par[req_addr][i] <= (^req_wdata[8*i +: 8]) ^ ((i == 0) & perr_inject);
         end
      end
   end

   always_comb begin
      rd_perr = 1'b0;
      for (int i = 0; i < NB; i++) begin
         rd_perr = rd_perr | (par[req_addr][i] ^ (^mem[req_addr][8*i +: 8]));
      end
   end
`else
   logic unused_perr_inject;
   assign unused_perr_inject = perr_inject;
   assign rd_perr            = 1'b0;
`endif

   // Stages only load behind a valid beat, so the last stage holds its data between responses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q  <= '0;
         perr_q <= '0;
         for (int i = 0; i < RD_LAT; i++) dat_q[i] <= '0;
      end else begin
         vld_q[0] <= rd_fire;
         if (rd_fire) begin
            dat_q[0]  <= mem[req_addr];
            perr_q[0] <= rd_perr;
         end
         for (int i = 1; i < RD_LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            if (vld_q[i-1]) begin
               dat_q[i]  <= dat_q[i-1];
               perr_q[i] <= perr_q[i-1];
            end
         end
      end
   end

   assign rsp_valid = vld_q[RD_LAT-1];
   assign rsp_rdata = dat_q[RD_LAT-1];
   assign rsp_perr  = vld_q[RD_LAT-1] & perr_q[RD_LAT-1];

   a_req_known: assert property (@(posedge clk) disable iff (!rst_n)
      fire |-> !$isunknown({req_addr, req_write}));
   a_no_rsp_in_clear: assert property (@(posedge clk) disable iff (!rst_n)
      (state_q == StClear) |-> !rsp_valid);

endmodule

// File: tb/tb_sync_mem_ctrl.sv
// Scoreboard bench for sync_mem_ctrl: driver pushes expected read responses from a word-array
// model; a negedge monitor pops and checks data, parity flag and arrival cycle.
module tb_sync_mem_ctrl;
   localparam int unsigned AW    = 4;
   localparam int unsigned DW    = 16;
   localparam int unsigned NB    = DW / 8;
   localparam int unsigned LAT   = 3;
   localparam int unsigned DEPTH = 2 ** AW;
`ifdef MEM_PARITY_EN
   localparam bit PARITY = 1'b1;
`else
   localparam bit PARITY = 1'b0;
`endif

   logic          clk = 1'b0, rst_n = 1'b0;
   logic          req_valid = 1'b0, req_write = 1'b0, clr_start = 1'b0, perr_inject = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic [NB-1:0] req_be = '0;
   logic          req_ready, rsp_valid, rsp_perr, busy;
   logic [DW-1:0] rsp_rdata;

   sync_mem_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT), .CLR_RST(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .clr_start(clr_start), .perr_inject(perr_inject), .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata), .rsp_perr(rsp_perr), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] data;
      logic          perr;
      int unsigned   due;
   } exp_t;

   exp_t          sb[$];
   logic [DW-1:0] mdl_mem [DEPTH];
   bit            mdl_bad [DEPTH];
   int unsigned   n_chk = 0, n_pass = 0, ncyc = 0;
   logic [DW-1:0] last_data = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Monitor: ncyc counts negedges; the driver reads it pre-update at the same negedge.
   always @(negedge clk) begin : b_mon
      exp_t e;
      if (!rst_n) begin
         last_data = '0;
      end else if (rsp_valid) begin
         if (sb.size() == 0) begin
            chk("unexpected_rsp", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("rdata", rsp_rdata, e.data);
            chk("perr", rsp_perr, e.perr);
            chk("latency", ncyc, e.due);
            chk("rsp_in_clear", busy, 1'b0);
         end
         last_data = rsp_rdata;
      end else begin
         chk("rdata_hold", rsp_rdata, last_data);
      end
      ncyc <= ncyc + 1;
   end

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) begin
         mdl_mem[i] = '0;
         mdl_bad[i] = 1'b0;
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting posedge.
   task automatic issue(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [NB-1:0] be, input bit inj);
      int unsigned waited = 0;
      exp_t e;
      req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
      perr_inject = inj;
      while (!req_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (!req_ready) begin
         chk("ready_timeout", 32'd0, 32'd1);
         req_valid = 1'b0;
         return;
      end
      if (w) begin
         for (int i = 0; i < NB; i++) if (be[i]) mdl_mem[a][8*i +: 8] = d[8*i +: 8];
         if (be[0]) mdl_bad[a] = PARITY && inj;
      end else begin
         e.data = mdl_mem[a];
         e.perr = PARITY ? mdl_bad[a] : 1'b0;
         e.due  = ncyc + LAT;
         sb.push_back(e);
      end
      @(negedge clk);
   endtask

   task automatic idle();
      req_valid = 1'b0; perr_inject = 1'b0;
      @(negedge clk);
   endtask

   task automatic clr();
      int unsigned waited = 0;
      req_valid = 1'b0; perr_inject = 1'b0;
      while (!req_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      clr_start = 1'b1;
      model_clear();
      @(negedge clk);
      clr_start = 1'b0;
   endtask

   // Waits for busy, then counts busy cycles and watches req_ready stays low.
   task automatic sweep(input string name);
      int unsigned n = 0, w = 0;
      bit rdy_seen = 1'b0;
      while (!busy && w < 50) begin
         @(negedge clk);
         w++;
      end
      while (busy && n < 100) begin
         if (req_ready) rdy_seen = 1'b1;
         n++;
         @(negedge clk);
      end
      chk(name, n, DEPTH);
      chk({name, "_ready_low"}, rdy_seen, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
      $fatal(1);
   end

   initial begin
      int unsigned w;
      model_clear();
      repeat (3) @(negedge clk);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rdata", rsp_rdata, '0);
      chk("rst_perr", rsp_perr, 1'b0);
      chk("rst_busy", busy, 1'b1);
      chk("rst_ready", req_ready, 1'b0);

      // Reset in the middle of a sweep must restart it from address 0.
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_mid_busy", busy, 1'b1);
      rst_n = 1'b1;
      sweep("sweep_after_reset");

      for (int a = 0; a < DEPTH; a++) issue(1'b0, AW'(a), '0, '0, 1'b0);
      idle();

      issue(1'b1, 4'h3, 16'hBEEF, 2'b11, 1'b0);
      issue(1'b0, 4'h3, '0, '0, 1'b0);
      issue(1'b1, 4'h3, 16'h1234, 2'b01, 1'b0);
      issue(1'b0, 4'h3, '0, '0, 1'b0);
      issue(1'b1, 4'h3, 16'hFFFF, 2'b00, 1'b0);
      issue(1'b0, 4'h3, '0, '0, 1'b0);
      idle();

      for (int a = 0; a < 4; a++) issue(1'b1, AW'(a), 16'hA000 + 16'(a * 17), 2'b11, 1'b0);
      for (int a = 0; a < 4; a++) issue(1'b0, AW'(a), '0, '0, 1'b0);
      idle();

      issue(1'b1, 4'h5, 16'h00FF, 2'b11, 1'b1);
      issue(1'b0, 4'h5, '0, '0, 1'b0);
      issue(1'b1, 4'h6, 16'h00FF, 2'b11, 1'b0);
      issue(1'b0, 4'h6, '0, '0, 1'b0);
      idle();

      // Clear with two reads in flight: both must still arrive with pre-clear data.
      issue(1'b0, 4'h0, '0, '0, 1'b0);
      issue(1'b0, 4'h1, '0, '0, 1'b0);
      clr();
      sweep("sweep_on_demand");
      for (int a = 0; a < DEPTH; a++) issue(1'b0, AW'(a), '0, '0, 1'b0);
      idle();

      for (int n = 0; n < 400; n++) begin
         int unsigned r;
         r = $urandom_range(0, 99);
         if (r < 2) clr();
         else if (r < 12) idle();
         else issue(r[0], AW'($urandom), DW'($urandom), NB'($urandom),
                    ($urandom_range(0, 3) == 0));
      end
      idle();

      w = 0;
      while (sb.size() != 0 && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk("sb_drained", sb.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
